// File: rtl/seq_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_pkg
// Purpose  : Shared types and constants for the BBCCC sequence generator.
//            Holds the FSM state encoding, the default pattern, and the
//            seed/tap constants of the optional gap-fill LFSR.
// Revision : 1.0 - initial release
// ============================================================================
package seq_gen_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default pattern: B=1, C=0, sent MSB first
    localparam int               c_DEF_PLEN    = 5;
    localparam logic [4:0]       c_DEF_PATTERN = 5'b11000;

    // Counter widths
    localparam int               c_BIT_W = 3;
    localparam int               c_REP_W = 4;
    localparam int               c_GAP_W = 2;

    // Gap-fill LFSR: x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form
    localparam logic [7:0]       c_LFSR_SEED = 8'hA5;
    localparam logic [7:0]       c_LFSR_TAPS = 8'hB8;

endpackage : seq_gen_pkg
`default_nettype wire

// File: rtl/seq_gen_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_lfsr
// Purpose  : 8-bit Fibonacci LFSR used to fill idle gap bit-times.
//            Shifts toward the MSB; bit_out is the current MSB.
//            Synchronous active-low reset reloads the seed.
// Revision : 1.0 - initial release
// ============================================================================
module seq_gen_lfsr
    import seq_gen_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_out
);

    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb    = ^(r_lfsr & c_LFSR_TAPS);
    assign bit_out = r_lfsr[7];

    // Advance once per enabled cycle; reset reloads the seed
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lfsr <= c_LFSR_SEED;
        end else if (en) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end

endmodule : seq_gen_lfsr
`default_nettype wire

// File: rtl/seq_gen_bbccc.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_bbccc
// Purpose  : Serial generator that sends a PLEN-bit pattern (default BBCCC,
//            B=1 C=0, MSB first) count times with gap idle bit-times between
//            repetitions, then pulses done.
//            Optional macro SEQ_GEN_LFSR_FILL_EN: gap cycles carry LFSR
//            fill data on dout instead of 0.
// Revision : 1.0 - initial release
// ============================================================================
module seq_gen_bbccc
    import seq_gen_pkg::*;
#(
    parameter int              PLEN    = c_DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = c_DEF_PATTERN
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [c_REP_W-1:0] count,
    input  logic [c_GAP_W-1:0] gap,
    output logic               dout,
    output logic               valid,
    output logic               frame,
    output logic               busy,
    output logic               done
);

    localparam logic [c_BIT_W-1:0] c_BIT_TOP = c_BIT_W'(PLEN - 1);

    state_t               r_state, w_state_n;
    logic [c_BIT_W-1:0]   r_bit,   w_bit_n;
    logic [c_REP_W-1:0]   r_rep,   w_rep_n;
    logic [c_GAP_W-1:0]   r_gap,   w_gap_n;
    logic [c_GAP_W-1:0]   r_gcnt,  w_gcnt_n;

    logic r_dout, r_valid, r_frame, r_busy, r_done;
    logic w_dout_n, w_valid_n, w_frame_n, w_busy_n, w_done_n;
    logic w_fill;

`ifdef SEQ_GEN_LFSR_FILL_EN
    // Fill source advances exactly once per GAP cycle
    seq_gen_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .en      (w_state_n == GAP),
        .bit_out (w_fill)
    );
`else
    assign w_fill = 1'b0;
`endif

    // Next-state and counter update
    always_comb begin
        w_state_n = r_state;
        w_bit_n   = r_bit;
        w_rep_n   = r_rep;
        w_gap_n   = r_gap;
        w_gcnt_n  = r_gcnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_state_n = SEND;
                        w_bit_n   = c_BIT_TOP;
                        w_rep_n   = count;
                        w_gap_n   = gap;
                    end else begin
                        w_state_n = DONE;
                    end
                end
            end
            SEND: begin
                if (r_bit == '0) begin
                    // One repetition completed
                    w_rep_n = r_rep - 4'd1;
                    if (r_rep == 4'd1) begin
                        w_state_n = DONE;
                    end else if (r_gap != '0) begin
                        w_state_n = GAP;
                        w_gcnt_n  = r_gap - 2'd1;
                    end else begin
                        w_bit_n   = c_BIT_TOP;
                    end
                end else begin
                    w_bit_n = r_bit - 3'd1;
                end
            end
            GAP: begin
                if (r_gcnt == '0) begin
                    w_state_n = SEND;
                    w_bit_n   = c_BIT_TOP;
                end else begin
                    w_gcnt_n  = r_gcnt - 2'd1;
                end
            end
            DONE: begin
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, registered below
    always_comb begin
        w_valid_n = (w_state_n == SEND);
        w_frame_n = w_valid_n && (w_bit_n == c_BIT_TOP);
        w_busy_n  = (w_state_n == SEND) || (w_state_n == GAP);
        w_done_n  = (w_state_n == DONE);
        w_dout_n  = 1'b0;
        if (w_valid_n) begin
            w_dout_n = PATTERN[w_bit_n];
        end else if (w_state_n == GAP) begin
            w_dout_n = w_fill;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_rep   <= '0;
            r_gap   <= '0;
            r_gcnt  <= '0;
            r_dout  <= 1'b0;
            r_valid <= 1'b0;
            r_frame <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_bit   <= w_bit_n;
            r_rep   <= w_rep_n;
            r_gap   <= w_gap_n;
            r_gcnt  <= w_gcnt_n;
            r_dout  <= w_dout_n;
            r_valid <= w_valid_n;
            r_frame <= w_frame_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign dout  = r_dout;
    assign valid = r_valid;
    assign frame = r_frame;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule : seq_gen_bbccc
`default_nettype wire

// File: tb/tb_seq_gen_bbccc.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_gen_bbccc
// Purpose  : Scoreboard bench for seq_gen_bbccc. The driver computes the
//            expected cycle of every pattern bit, gap cycle and done pulse
//            from the sequence rules and queues them; a negedge monitor
//            compares the DUT against those queues every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_gen_bbccc;

    localparam int PLEN = 5;

    typedef struct {
        int cyc;
        bit d;
        bit f;
    } bit_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] count;
    logic [1:0] gap;
    logic       dout, valid, frame, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    bit_exp_t   q_bits[$];
    int         q_gap[$];
    int         q_done[$];
    int         busy_lo = 1;
    int         busy_hi = 0;
    int         next_free = 0;
    int         cur_ts = 0;
    int         cur_done = 0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [4:0] pat_v = 5'b11000;

    // overlapping BBCCC detector over contiguous valid bits
    logic [4:0] det_win = '0;
    int         det_run = 0;
    int         det_cnt = 0;

    seq_gen_bbccc dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .count (count),
        .gap   (gap),
        .dout  (dout),
        .valid (valid),
        .frame (frame),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every cycle against the scoreboard queues
    always @(negedge clk) begin : b_mon
        bit in_bit, in_gap, in_done;
        if (mon_en) begin
            in_bit  = (q_bits.size() > 0) && (q_bits[0].cyc == cyc);
            in_gap  = (q_gap.size()  > 0) && (q_gap[0]      == cyc);
            in_done = (q_done.size() > 0) && (q_done[0]     == cyc);

            chk("valid", valid, in_bit);
            if (in_bit) begin
                chk("dout", dout, q_bits[0].d);
                chk("frame", frame, q_bits[0].f);
                void'(q_bits.pop_front());
            end else begin
                chk("frame_idle", frame, 0);
            end

            if (in_gap) begin
`ifdef SEQ_GEN_LFSR_FILL_EN
                chk("gap_fill", dout, m_lfsr[7]);
                m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
`else
                chk("gap_dout", dout, 0);
`endif
                void'(q_gap.pop_front());
            end else if (!in_bit) begin
                chk("dout_idle", dout, 0);
            end

            chk("done", done, in_done);
            if (in_done) void'(q_done.pop_front());

            chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));

            if (valid === 1'b1) begin
                det_win = {det_win[3:0], dout};
                det_run++;
                if (det_run >= 5 && det_win == 5'b11000) det_cnt++;
            end else begin
                det_run = 0;
            end
        end
    end

    task automatic wait_free();
        int guard = 0;
        @(negedge clk); #2;
        while (cyc < next_free && guard < 1000) begin
            @(negedge clk); #2;
            guard++;
        end
        if (guard >= 1000) chk("wait_timeout", 1, 0);
    endtask

    // Issue one request and queue everything the sequence rules predict
    task automatic issue(input int cnt, input int g);
        int ts, base;
        wait_free();
        start = 1'b1;
        count = 4'(cnt);
        gap   = 2'(g);
        ts    = cyc + 1;
        for (int r = 0; r < cnt; r++) begin
            base = ts + r * (PLEN + g);
            for (int i = 0; i < PLEN; i++)
                q_bits.push_back('{cyc: base + i, d: pat_v[PLEN-1-i], f: (i == 0)});
            if (r < cnt - 1)
                for (int k = 0; k < g; k++) q_gap.push_back(base + PLEN + k);
        end
        cur_ts   = ts;
        cur_done = (cnt == 0) ? ts : ts + PLEN * cnt + g * (cnt - 1);
        q_done.push_back(cur_done);
        busy_lo   = ts;
        busy_hi   = (cnt == 0) ? ts - 1 : cur_done - 1;
        next_free = cur_done + 1;
        @(negedge clk); #2;
        start = 1'b0;
        count = 4'($urandom);
        gap   = 2'($urandom);
    endtask

    // Pulse start somewhere between acceptance and the done cycle
    task automatic stray_start();
        int c;
        c = $urandom_range(cur_done, cur_ts);
        while (cyc < c) begin
            @(negedge clk); #2;
        end
        start = 1'b1;
        count = 4'($urandom_range(15, 1));
        gap   = 2'($urandom);
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    initial begin : b_timeout
        #1000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : b_drive
        int cnt, g;
        rst   = 1'b0;
        start = 1'b1;
        count = 4'd3;
        gap   = 2'd0;

        // reset held with start high: nothing may come out
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk); #2;
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        start = 1'b0;
        rst   = 1'b1;
        next_free = cyc;

        // single repetition, no gap
        issue(1, 0);

        // three back-to-back repetitions; detector sees three patterns
        wait_free();
        det_cnt = 0;
        issue(3, 0);
        wait_free();
        chk("detector", det_cnt, 3);

        // gapped repetitions
        issue(2, 2);

        // zero count with a stray start during DONE
        issue(0, 0);
        stray_start();

        // stray start while sending
        issue(4, 1);
        stray_start();

        // reset during bit 2, with start asserted alongside
        issue(2, 1);
        while (cyc < cur_ts + 2) begin
            @(negedge clk); #2;
        end
        rst   = 1'b0;
        start = 1'b1;
        count = 4'd2;
        q_bits.delete();
        q_gap.delete();
        q_done.delete();
        busy_lo = 1;
        busy_hi = 0;
        m_lfsr  = 8'hA5;
        @(negedge clk); #2;
        chk("abort_valid", valid, 0);
        chk("abort_dout", dout, 0);
        chk("abort_frame", frame, 0);
        rst   = 1'b1;
        start = 1'b0;
        next_free = cyc;
        issue(1, 0);

        // randomized requests, occasionally with stray starts
        for (int n = 0; n < 30; n++) begin
            cnt = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(6, 1);
            g   = $urandom_range(3, 0);
            issue(cnt, g);
            if ($urandom_range(1, 0) == 1) stray_start();
        end

        wait_free();
        repeat (4) @(negedge clk);
        #2;
        chk("bits_drained", q_bits.size(), 0);
        chk("done_drained", q_done.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_gen_bbccc
`default_nettype wire
